// File: rtl/ysyx_25050148_alu_arbiter.sv
// rtl/ysyx_25050148_alu_arbiter.sv - round-robin sharing of one ALU between the EXU and the branch/address unit
module ysyx_25050148_alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid0,
  input  logic                  req_valid1,
  output logic                  req_ready0,
  output logic                  req_ready1,
  input  logic [DATA_WIDTH-1:0] req_src1_0,
  input  logic [DATA_WIDTH-1:0] req_src1_1,
  input  logic [DATA_WIDTH-1:0] req_src2_0,
  input  logic [DATA_WIDTH-1:0] req_src2_1,
  input  logic [3:0]            req_opt0,
  input  logic [3:0]            req_opt1,
  input  logic [2:0]            req_inst_type0,
  input  logic [2:0]            req_inst_type1,
  input  logic [2:0]            req_func3_0,
  input  logic [2:0]            req_func3_1,
  input  logic [6:0]            req_func7_0,
  input  logic [6:0]            req_func7_1,
  output logic                  resp_valid0,
  output logic                  resp_valid1,
  input  logic                  resp_ready0,
  input  logic                  resp_ready1,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_branch,
  output logic [DATA_WIDTH-1:0] alu_src1,
  output logic [DATA_WIDTH-1:0] alu_src2,
  output logic [3:0]            alu_opt,
  output logic [2:0]            alu_inst_type,
  output logic [2:0]            alu_func3,
  output logic [6:0]            alu_func7,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_branch_flag,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   owner;
  logic   grant0;
  logic   grant1;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant0 = req_valid0 && (!req_valid1 || last_grant);
    grant1 = req_valid1 && (!req_valid0 || !last_grant);
  end

  assign req_ready0 = (state == IDLE) && grant0;
  assign req_ready1 = (state == IDLE) && grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      alu_src1      <= '0;
      alu_src2      <= '0;
      alu_opt       <= '0;
      alu_inst_type <= '0;
      alu_func3     <= '0;
      alu_func7     <= '0;
      resp_result   <= '0;
      resp_branch   <= 1'b0;
      resp_valid0   <= 1'b0;
      resp_valid1   <= 1'b0;
      grant_cnt0    <= '0;
      grant_cnt1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready0) begin
            alu_src1      <= req_src1_0;
            alu_src2      <= req_src2_0;
            alu_opt       <= req_opt0;
            alu_inst_type <= req_inst_type0;
            alu_func3     <= req_func3_0;
            alu_func7     <= req_func7_0;
            owner         <= 1'b0;
            last_grant    <= 1'b0;
            grant_cnt0    <= grant_cnt0 + CNT_WIDTH'(1);
            state         <= EXEC;
          end else if (req_ready1) begin
            alu_src1      <= req_src1_1;
            alu_src2      <= req_src2_1;
            alu_opt       <= req_opt1;
            alu_inst_type <= req_inst_type1;
            alu_func3     <= req_func3_1;
            alu_func7     <= req_func7_1;
            owner         <= 1'b1;
            last_grant    <= 1'b1;
            grant_cnt1    <= grant_cnt1 + CNT_WIDTH'(1);
            state         <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_branch <= alu_branch_flag;
          resp_valid0 <= !owner;
          resp_valid1 <= owner;
          state       <= RESP;
        end
        RESP: begin
          // Returning to IDLE here means the next accept is at least one cycle later.
          if ((resp_valid0 && resp_ready0) || (resp_valid1 && resp_ready1)) begin
            resp_valid0 <= 1'b0;
            resp_valid1 <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25050148_alu_arbiter.sv
// tb/tb_ysyx_25050148_alu_arbiter.sv - vector table, corner sequences and random traffic against a transaction model
module tb_ysyx_25050148_alu_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic req_valid0, req_valid1, req_ready0, req_ready1;
  logic [DW-1:0] req_src1_0, req_src1_1, req_src2_0, req_src2_1;
  logic [3:0] req_opt0, req_opt1;
  logic [2:0] req_inst_type0, req_inst_type1, req_func3_0, req_func3_1;
  logic [6:0] req_func7_0, req_func7_1;
  logic resp_valid0, resp_valid1, resp_ready0, resp_ready1;
  logic [DW-1:0] resp_result;
  logic resp_branch;
  logic [DW-1:0] alu_src1, alu_src2, alu_result;
  logic [3:0] alu_opt;
  logic [2:0] alu_inst_type, alu_func3;
  logic [6:0] alu_func7;
  logic alu_branch_flag;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ysyx_25050148_alu_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_src1_0(req_src1_0), .req_src1_1(req_src1_1),
    .req_src2_0(req_src2_0), .req_src2_1(req_src2_1),
    .req_opt0(req_opt0), .req_opt1(req_opt1),
    .req_inst_type0(req_inst_type0), .req_inst_type1(req_inst_type1),
    .req_func3_0(req_func3_0), .req_func3_1(req_func3_1),
    .req_func7_0(req_func7_0), .req_func7_1(req_func7_1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
    .resp_result(resp_result), .resp_branch(resp_branch),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_opt(alu_opt),
    .alu_inst_type(alu_inst_type), .alu_func3(alu_func3), .alu_func7(alu_func7),
    .alu_result(alu_result), .alu_branch_flag(alu_branch_flag),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  function automatic logic [DW-1:0] alu_f(input logic [3:0] opt, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [6:0] f7);
    case (opt)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0011: return a & b;
      4'b0100: return a | b;
      4'b0101: return a ^ b;
      4'b0110: return {31'd0, $signed(a) < $signed(b)};
      4'b0111: return {31'd0, a == b};
      4'b1000: return a << b[4:0];
      4'b1001: return f7[5] ? DW'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      default: return '0;
    endcase
  endfunction

  function automatic logic br_f(input logic [2:0] itype, input logic [2:0] f3, input logic [DW-1:0] res);
    if (itype != 3'd0) return 1'b0;
    return (f3 == 3'd1) ? (res == '0) : res[0];
  endfunction

  assign alu_result      = alu_f(alu_opt, alu_src1, alu_src2, alu_func7);
  assign alu_branch_flag = br_f(alu_inst_type, alu_func3, alu_result);

  typedef struct {
    int          who;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  opt;
    logic [2:0]  itype;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp_res;
    logic        exp_br;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input int who, input logic v, input vec_t r);
    if (who == 0) begin
      req_valid0 = v; req_src1_0 = r.src1; req_src2_0 = r.src2; req_opt0 = r.opt;
      req_inst_type0 = r.itype; req_func3_0 = r.f3; req_func7_0 = r.f7;
    end else begin
      req_valid1 = v; req_src1_1 = r.src1; req_src2_1 = r.src2; req_opt1 = r.opt;
      req_inst_type1 = r.itype; req_func3_1 = r.f3; req_func7_1 = r.f7;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    drive(v.who, 1'b1, v);
    drive(1 - v.who, 1'b0, v);
    resp_ready0 = 1'b1; resp_ready1 = 1'b1;
    @(negedge clk);
    chk("vec_ready", v.who == 0 ? req_ready0 : req_ready1, 1);
    @(posedge clk); #1;
    drive(v.who, 1'b0, v);
    @(negedge clk);
    chk("vec_alu_opt", alu_opt, v.opt);
    chk("vec_alu_src1", alu_src1, v.src1);
    chk("vec_alu_src2", alu_src2, v.src2);
    chk("vec_exec_valid", resp_valid0 | resp_valid1, 0);
    @(negedge clk);
    chk("vec_owner_valid", v.who == 0 ? resp_valid0 : resp_valid1, 1);
    chk("vec_other_valid", v.who == 0 ? resp_valid1 : resp_valid0, 0);
    chk("vec_result", resp_result, v.exp_res);
    chk("vec_branch", resp_branch, v.exp_br);
    @(negedge clk);
    chk("vec_valid_cleared", resp_valid0 | resp_valid1, 0);
  endtask

  initial begin
    vec_t nv, a, b;
    logic [31:0] opcodes[9];
    int ph, mc0, mc1;
    logic mlast, mown, mbr, g0, g1;
    logic [31:0] mres, msrc1;

    opcodes = '{32'd0, 32'd1, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    vecs[0] = '{0, 32'd5, 32'd7, 4'b0000, 3'd1, 3'd0, 7'h00, 32'd12, 1'b0};
    vecs[1] = '{1, 32'd9, 32'd9, 4'b0111, 3'd0, 3'd0, 7'h00, 32'd1, 1'b1};
    vecs[2] = '{1, 32'd9, 32'd8, 4'b0111, 3'd0, 3'd0, 7'h00, 32'd0, 1'b0};
    vecs[3] = '{0, 32'h8000_0000, 32'd4, 4'b1001, 3'd1, 3'd5, 7'h20, 32'hF800_0000, 1'b0};
    vecs[4] = '{0, 32'h8000_0000, 32'd4, 4'b1001, 3'd1, 3'd5, 7'h00, 32'h0800_0000, 1'b0};
    vecs[5] = '{1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0011, 3'd1, 3'd7, 7'h00, 32'h0000_F000, 1'b0};
    vecs[6] = '{0, 32'hFFFF_FFFF, 32'd1, 4'b0110, 3'd1, 3'd2, 7'h00, 32'd1, 1'b0};
    nv = '{0, 32'd0, 32'd0, 4'd0, 3'd0, 3'd0, 7'd0, 32'd0, 1'b0};

    rst = 1'b1;
    drive(0, 1'b0, nv); drive(1, 1'b0, nv);
    resp_ready0 = 1'b0; resp_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_alu_src1", alu_src1, 0);
    chk("rst_alu_opt", alu_opt, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_valid", {resp_valid1, resp_valid0}, 0);
    chk("rst_cnt", {grant_cnt1, grant_cnt0}, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("t1_cnt0", grant_cnt0, 1);
    end
    chk("tbl_cnt0", grant_cnt0, 4);
    chk("tbl_cnt1", grant_cnt1, 3);

    // Alternation with both requesters always valid.
    do_reset();
    a = '{0, 32'hF0, 32'h0F, 4'b0101, 3'd1, 3'd4, 7'h00, 32'hFF, 1'b0};
    b = '{1, 32'd10, 32'd3, 4'b0001, 3'd1, 3'd0, 7'h20, 32'd7, 1'b0};
    @(posedge clk); #1;
    drive(0, 1'b1, a); drive(1, 1'b1, b);
    resp_ready0 = 1'b1; resp_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_ready0", req_ready0, (k % 2) == 0);
      chk("rr_ready1", req_ready1, (k % 2) == 1);
      @(negedge clk);
      chk("rr_exec_ready", {req_ready1, req_ready0}, 0);
      @(negedge clk);
      chk("rr_valid0", resp_valid0, (k % 2) == 0);
      chk("rr_valid1", resp_valid1, (k % 2) == 1);
      chk("rr_result", resp_result, (k % 2) == 0 ? 32'hFF : 32'd7);
      chk("rr_resp_ready", {req_ready1, req_ready0}, 0);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, a); drive(1, 1'b0, b);
    chk("rr_cnt0", grant_cnt0, 2);
    chk("rr_cnt1", grant_cnt1, 2);

    // Backpressure on requester 0 while requester 1 waits.
    a = '{0, 32'd1, 32'd31, 4'b1000, 3'd1, 3'd1, 7'h00, 32'h8000_0000, 1'b0};
    @(posedge clk); #1;
    drive(0, 1'b1, a);
    @(negedge clk);
    chk("bp_ready0", req_ready0, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, a); drive(1, 1'b1, b);
    resp_ready0 = 1'b0;
    @(negedge clk);
    chk("bp_exec_ready1", req_ready1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid0", resp_valid0, 1);
      chk("bp_result", resp_result, 32'h8000_0000);
      chk("bp_ready1", req_ready1, 0);
    end
    @(posedge clk); #1;
    resp_ready0 = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready1", req_ready1, 0);
    @(negedge clk);
    chk("bp_after_ready1", req_ready1, 1);
    chk("bp_after_valid0", resp_valid0, 0);
    @(posedge clk); #1;
    drive(1, 1'b0, b);
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid1", resp_valid1, 1);
    chk("bp_result1", resp_result, 32'd7);
    @(negedge clk);

    // Asynchronous reset while a request is executing.
    @(posedge clk); #1;
    drive(0, 1'b1, vecs[0]);
    @(posedge clk); #1;
    drive(0, 1'b0, vecs[0]);
    #2 rst = 1'b1;
    #1;
    chk("ar_alu_src1", alu_src1, 0);
    chk("ar_alu_opt", alu_opt, 0);
    chk("ar_resp_result", resp_result, 0);
    chk("ar_cnt", {grant_cnt1, grant_cnt0}, 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ar_no_valid", {resp_valid1, resp_valid0}, 0);
    end
    @(posedge clk); #1;
    drive(0, 1'b1, a); drive(1, 1'b1, b);
    @(negedge clk);
    chk("ar_tie_ready0", req_ready0, 1);
    chk("ar_tie_ready1", req_ready1, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, a); drive(1, 1'b0, b);

    // Random traffic against a transaction-level model.
    do_reset();
    ph = 0; mlast = 1'b1; mown = 1'b0; mres = '0; mbr = 1'b0; msrc1 = '0; mc0 = 0; mc1 = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int w = 0; w < 2; w++) begin
        vec_t r;
        r.who = w;
        r.src1 = $urandom; r.src2 = $urandom;
        r.opt = opcodes[$urandom_range(0, 8)][3:0];
        r.itype = 3'($urandom_range(0, 2)); r.f3 = 3'($urandom); r.f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        r.exp_res = '0; r.exp_br = 1'b0;
        drive(w, ($urandom_range(0, 2) != 0), r);
      end
      resp_ready0 = ($urandom_range(0, 2) != 0);
      resp_ready1 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      chk("rnd_cnt0", grant_cnt0, mc0);
      chk("rnd_cnt1", grant_cnt1, mc1);
      case (ph)
        0: begin
          g0 = req_valid0 && (!req_valid1 || mlast);
          g1 = req_valid1 && (!req_valid0 || !mlast);
          chk("rnd_ready0", req_ready0, g0);
          chk("rnd_ready1", req_ready1, g1);
          if (g0 || g1) begin
            mown = g1; mlast = g1;
            msrc1 = g1 ? req_src1_1 : req_src1_0;
            mres = g1 ? alu_f(req_opt1, req_src1_1, req_src2_1, req_func7_1)
                      : alu_f(req_opt0, req_src1_0, req_src2_0, req_func7_0);
            mbr = g1 ? br_f(req_inst_type1, req_func3_1, mres) : br_f(req_inst_type0, req_func3_0, mres);
            if (g1) mc1 = (mc1 + 1) % 16; else mc0 = (mc0 + 1) % 16;
            ph = 1;
          end
        end
        1: begin
          chk("rnd_exec_ready", {req_ready1, req_ready0}, 0);
          chk("rnd_exec_valid", {resp_valid1, resp_valid0}, 0);
          chk("rnd_alu_src1", alu_src1, msrc1);
          ph = 2;
        end
        default: begin
          chk("rnd_resp_ready", {req_ready1, req_ready0}, 0);
          chk("rnd_valid0", resp_valid0, !mown);
          chk("rnd_valid1", resp_valid1, mown);
          chk("rnd_result", resp_result, mres);
          chk("rnd_branch", resp_branch, mbr);
          if (mown ? resp_ready1 : resp_ready0) ph = 0;
        end
      endcase
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
